// File: rtl/y86_writeback_pkg.sv
// ----------------------------------------------------------------------------
// y86_writeback_pkg
// Shared definitions for the Y86-64 write-back slice.
//   - Y86 instruction codes (HALT..POPL)
//   - Register index constants (REG_NONE marks "no destination / no source")
//   - Default widths for the register file and retire counter
//   - Write-back FSM state encoding
// ----------------------------------------------------------------------------
package y86_writeback_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;
    localparam int NREGS      = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    // IDLE accepts requests; WRITE_M drains the second destination of a
    // two-destination instruction through the single write port.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WRITE_M = 1'b1
    } wb_state_t;

    // cmovXX whose condition failed behaves as if it had no E destination.
    function automatic logic [3:0] gate_dst_e(input logic [3:0] icode,
                                              input logic       cnd,
                                              input logic [3:0] dst_e);
        return (icode == I_RRMOVL && !cnd) ? REG_NONE : dst_e;
    endfunction

endpackage

// File: rtl/y86_writeback_if.sv
// ----------------------------------------------------------------------------
// y86_writeback_if
// Bundles the write-back request channel, the two decode read ports and the
// retire status of the write-back block.
//   master : upstream pipeline / decode side (drives requests and read indices)
//   slave  : the write-back block itself
// Signals:
//   valid, ready                 request handshake
//   icode, dst_e, dst_m, cnd     retiring instruction descriptor
//   val_e, val_m                 ALU and memory results
//   src_a, src_b / val_a, val_b  combinational read ports
//   retired, retire_cnt          retire pulse and running count
// ----------------------------------------------------------------------------
interface y86_writeback_if
    import y86_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              valid;
    logic              ready;
    logic [3:0]        icode;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_m;
    logic              cnd;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              retired;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output valid, icode, dst_e, dst_m, val_e, val_m, cnd, src_a, src_b,
        input  ready, val_a, val_b, retired, retire_cnt
    );

    modport slave (
        input  valid, icode, dst_e, dst_m, val_e, val_m, cnd, src_a, src_b,
        output ready, val_a, val_b, retired, retire_cnt
    );

endinterface

// File: rtl/y86_writeback_regfile.sv
// ----------------------------------------------------------------------------
// y86_regfile_1w2r
// Physical 15-entry register array: one synchronous write port, two
// combinational read ports. Reset loads each entry with its own index.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   we, waddr, wdata     write port (index REG_NONE is ignored)
//   raddr_a / rdata_a    read port A (REG_NONE reads as 0)
//   raddr_b / rdata_b    read port B (REG_NONE reads as 0)
// ----------------------------------------------------------------------------
module y86_regfile_1w2r
    import y86_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [0:NREGS-1];

    // Reset wins over any write in flight, so a write landing on the reset
    // edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (we && waddr != REG_NONE) begin
            regs[waddr] <= wdata;
        end
    end

    // Index 4'hF has no storage behind it; it reads as zero.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != REG_NONE) rdata_a = regs[raddr_a];
        if (raddr_b != REG_NONE) rdata_b = regs[raddr_b];
    end

endmodule

// File: rtl/y86_writeback.sv
// ----------------------------------------------------------------------------
// y86_writeback
// Write-back end of the Y86-64 register file. Accepts one retiring instruction
// per handshake and commits valE->dstE and valM->dstM. With only one write
// port, an instruction with two distinct live destinations takes two cycles
// and holds ready low during the second one.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        y86_writeback_if slave: request channel, read ports, retire
// ----------------------------------------------------------------------------
module y86_writeback
    import y86_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    y86_writeback_if.slave  bus
);

    wb_state_t         state;
    wb_state_t         next_state;
    logic [3:0]        pend_dst;
    logic [DATA_W-1:0] pend_val;
    logic              retired_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    logic              accept;
    logic [3:0]        eff_e;
    logic              we;
    logic [3:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              latch_pend;
    logic              retire_now;
    logic [DATA_W-1:0] arr_a;
    logic [DATA_W-1:0] arr_b;

    assign bus.ready  = (state == ST_IDLE);
    assign accept     = bus.valid && bus.ready;
    assign eff_e      = gate_dst_e(bus.icode, bus.cnd, bus.dst_e);

    y86_regfile_1w2r #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (bus.src_a),
        .raddr_b (bus.src_b),
        .rdata_a (arr_a),
        .rdata_b (arr_b)
    );

    // Decide what goes through the write port this cycle. When effE and dstM
    // name the same register (popq %rsp) only valM is written, so M wins
    // without needing a second cycle.
    always_comb begin
        next_state = state;
        we         = 1'b0;
        waddr      = REG_NONE;
        wdata      = '0;
        latch_pend = 1'b0;
        retire_now = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (eff_e != REG_NONE && bus.dst_m != REG_NONE && eff_e != bus.dst_m) begin
                        we         = 1'b1;
                        waddr      = eff_e;
                        wdata      = bus.val_e;
                        latch_pend = 1'b1;
                        next_state = ST_WRITE_M;
                    end else if (bus.dst_m != REG_NONE) begin
                        we         = 1'b1;
                        waddr      = bus.dst_m;
                        wdata      = bus.val_m;
                        retire_now = 1'b1;
                    end else if (eff_e != REG_NONE) begin
                        we         = 1'b1;
                        waddr      = eff_e;
                        wdata      = bus.val_e;
                        retire_now = 1'b1;
                    end else begin
                        retire_now = 1'b1;
                    end
                end
            end
            ST_WRITE_M: begin
                we         = 1'b1;
                waddr      = pend_dst;
                wdata      = pend_val;
                retire_now = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, pending M write and retire bookkeeping. The retire pulse is
    // registered so it appears in the cycle after the final write edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pend_dst     <= REG_NONE;
            pend_val     <= '0;
            retired_q    <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state     <= next_state;
            retired_q <= retire_now;
            if (latch_pend) begin
                pend_dst <= bus.dst_m;
                pend_val <= bus.val_m;
            end
            if (retire_now) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    // While the M write is still pending, reads of its register see the
    // pending value rather than the stale array contents. Incoming wb_* data
    // is deliberately not bypassed.
    always_comb begin
        bus.val_a = arr_a;
        bus.val_b = arr_b;
        if (state == ST_WRITE_M && bus.src_a != REG_NONE && bus.src_a == pend_dst) begin
            bus.val_a = pend_val;
        end
        if (state == ST_WRITE_M && bus.src_b != REG_NONE && bus.src_b == pend_dst) begin
            bus.val_b = pend_val;
        end
    end

    assign bus.retired    = retired_q;
    assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_y86_writeback.sv
// ----------------------------------------------------------------------------
// tb_y86_writeback
// Self-checking bench for y86_writeback: directed cases for reset, single and
// dual destination write-back, cmov gating, popq %rsp and reset mid-drain,
// then randomized instructions checked against a register-file model.
// ----------------------------------------------------------------------------
module tb_y86_writeback;
    import y86_writeback_pkg::*;

    localparam int DW = 64;
    localparam int CW = 32;

    logic clk;
    logic rst;

    y86_writeback_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    y86_writeback #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DW-1:0] modelRegs [0:NREGS-1];
    int unsigned   modelCnt;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) modelRegs[i] = DW'(i);
        modelCnt = 0;
    endtask

    task automatic readPorts(input logic [3:0] a, input logic [3:0] b);
        bus.src_a = a;
        bus.src_b = b;
        #1;
    endtask

    // Sweeps every register through both read ports against the model.
    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            readPorts(4'(i), 4'(NREGS - 1 - i));
            checkOutput({tag, "_rdA"}, bus.val_a, modelRegs[i]);
            checkOutput({tag, "_rdB"}, bus.val_b, modelRegs[NREGS - 1 - i]);
            #1;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Drives one instruction, checks the handshake, bypass and retire timing,
    // then folds its architectural effect into the model.
    task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] dE,
                                 input logic [3:0] dM, input logic [DW-1:0] vE,
                                 input logic [DW-1:0] vM, input logic cnd);
        logic [3:0] effE;
        logic       twoBeats;
        effE     = (icode == I_RRMOVL && !cnd) ? REG_NONE : dE;
        twoBeats = (effE != REG_NONE) && (dM != REG_NONE) && (effE != dM);

        @(negedge clk);
        checkOutput("ready_idle", DW'(bus.ready), DW'(1));
        bus.valid = 1'b1;
        bus.icode = icode;
        bus.dst_e = dE;
        bus.dst_m = dM;
        bus.val_e = vE;
        bus.val_m = vM;
        bus.cnd   = cnd;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.val_e = '1;
        bus.val_m = '1;

        if (twoBeats) begin
            checkOutput("ready_busy", DW'(bus.ready), DW'(0));
            checkOutput("retired_early", DW'(bus.retired), DW'(0));
            readPorts(dM, effE);
            checkOutput("bypass_m", bus.val_a, vM);
            checkOutput("first_e", bus.val_b, vE);
            @(posedge clk);
            #1;
        end

        if (effE != REG_NONE) modelRegs[effE] = vE;
        if (dM != REG_NONE) modelRegs[dM] = vM;
        modelCnt++;

        checkOutput("retired_pulse", DW'(bus.retired), DW'(1));
        checkOutput("ready_after", DW'(bus.ready), DW'(1));
        checkOutput("retire_cnt", DW'(bus.retire_cnt), DW'(modelCnt));
        readPorts(dM, effE);
        checkOutput("commit_m", bus.val_a, (dM == REG_NONE) ? '0 : modelRegs[dM]);
        checkOutput("commit_e", bus.val_b, (effE == REG_NONE) ? '0 : modelRegs[effE]);
        @(posedge clk);
        #1;
        checkOutput("retired_once", DW'(bus.retired), DW'(0));
    endtask

    initial begin
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.icode = I_NOP;
        bus.dst_e = REG_NONE;
        bus.dst_m = REG_NONE;
        bus.val_e = '0;
        bus.val_m = '0;
        bus.cnd   = 1'b0;
        bus.src_a = REG_NONE;
        bus.src_b = REG_NONE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        // Reset state
        readPorts(4'h3, REG_NONE);
        checkOutput("rst_valA", bus.val_a, DW'(3));
        checkOutput("rst_valB", bus.val_b, DW'(0));
        checkOutput("rst_ready", DW'(bus.ready), DW'(1));
        checkOutput("rst_cnt", DW'(bus.retire_cnt), DW'(0));
        checkOutput("rst_retired", DW'(bus.retired), DW'(0));
        checkAllRegs("rst");

        // irmovq, cmov not taken, cmov taken, popq %rbx, popq %rsp, nop
        applyStimulus(I_IRMOVL, 4'h2, REG_NONE, 64'h55, 64'h0, 1'b0);
        applyStimulus(I_RRMOVL, 4'h1, REG_NONE, 64'h99, 64'h0, 1'b0);
        applyStimulus(I_RRMOVL, 4'h5, REG_NONE, 64'h123, 64'h0, 1'b1);
        applyStimulus(I_POPL, 4'h4, 4'h3, 64'h100, 64'hAB, 1'b0);
        applyStimulus(I_POPL, REG_RSP, REG_RSP, 64'h108, 64'h77, 1'b0);
        applyStimulus(I_NOP, REG_NONE, REG_NONE, 64'hDEAD, 64'hBEEF, 1'b0);
        applyStimulus(I_MRMOVL, REG_NONE, 4'hE, 64'h0, 64'hCAFE, 1'b0);
        checkAllRegs("directed");

        // Reset while the M write of a popq is still pending
        @(negedge clk);
        bus.valid = 1'b1;
        bus.icode = I_POPL;
        bus.dst_e = REG_RSP;
        bus.dst_m = 4'h6;
        bus.val_e = 64'h200;
        bus.val_m = 64'h5A5A;
        bus.cnd   = 1'b0;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        checkOutput("midrst_busy", DW'(bus.ready), DW'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput("midrst_ready", DW'(bus.ready), DW'(1));
        checkOutput("midrst_cnt", DW'(bus.retire_cnt), DW'(0));
        checkOutput("midrst_retired", DW'(bus.retired), DW'(0));
        @(posedge clk);
        #1;
        checkOutput("midrst_no_late_retire", DW'(bus.retired), DW'(0));
        checkAllRegs("midrst");

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            logic [3:0]    ic;
            logic [3:0]    dE;
            logic [3:0]    dM;
            logic [DW-1:0] vE;
            logic [DW-1:0] vM;
            logic          c;
            ic = 4'($urandom_range(0, 11));
            dE = 4'($urandom_range(0, 15));
            dM = ($urandom_range(0, 7) == 0) ? dE : 4'($urandom_range(0, 15));
            vE = {$urandom, $urandom};
            vM = {$urandom, $urandom};
            c  = 1'($urandom);
            applyStimulus(ic, dE, dM, vE, vM, c);
            if (n % 25 == 24) checkAllRegs("rand");
        end

        applyReset();
        checkOutput("final_rst_cnt", DW'(bus.retire_cnt), DW'(0));
        checkAllRegs("final_rst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
